lab2_2_down: RTL
================

// Module: lab2_2_down
// PURPOSE
//  Modulo-N down-counter with parallel load; the count-down counterpart of the lab2 mod-12 up-counter.
//  Counts MODULUS-1 down to 0. When AUTO_RELOAD=1 it wraps back to MODULUS-1; when 0 it stops at 0.
//  Provides a level flag and a one-cycle borrow pulse for cascading into a higher digit.
//  Sits in the lab2 counter set as the timer/countdown digit.
// PARAMETERS
//  WIDTH        4   count width in bits; requires MODULUS <= 2**WIDTH
//  MODULUS      12  number of states; the count runs MODULUS-1 .. 0
//  AUTO_RELOAD  1   1: wrap 0 -> MODULUS-1; 0: stop in state DONE at 0
// PORTS
//  clock       in   1      rising-edge clock; the only clock
//  reset       in   1      synchronous, active-high reset
//  enable      in   1      count-down enable, sampled on clock
//  load        in   1      parallel load strobe, sampled on clock
//  load_value  in   WIDTH  value written by load
//  out         out  WIDTH  current count (registered)
//  underflow   out  1      level: high while out == 0 (decoded from the register)
//  borrow      out  1      registered pulse: high one cycle after a 0 -> MODULUS-1 wrap
//  running     out  1      high in state RUN
// BEHAVIOUR
//  Reset (clock edge with reset=1): out=MODULUS-1, borrow=0, state=RUN. Hence running=1, underflow=0.
//  Priority on each edge is reset > load > enable > hold.
//  States:
//   - RUN:  counting.
//   - DONE: reached only when AUTO_RELOAD=0. out is held at 0 and running=0.
//  Load (any state):
//   - out <= load_value. If load_value >= MODULUS, out <= MODULUS-1 (clamp).
//   - Next state is RUN. This applies even when the loaded value is 0.
//   - borrow <= 0. Load overrides enable in the same cycle.
//  RUN with enable=1:
//   - out != 0: out <= out-1. Arithmetic is unsigned WIDTH bits; out never takes a value >= MODULUS.
//   - out == 0 with AUTO_RELOAD=1: out <= MODULUS-1 and borrow <= 1 on the same edge.
//   - out == 0 with AUTO_RELOAD=0: out stays 0, state <= DONE, borrow <= 1.
//  RUN with enable=0: out holds and borrow <= 0.
//  DONE: out stays 0 and enable is ignored. Only load or reset leaves DONE.
//  Latency:
//   - Count changes one edge after enable is sampled.
//   - underflow follows out with no delay. borrow is aligned with the edge that performs the wrap.
//  Period: with enable held high and AUTO_RELOAD=1, the cycle is exactly MODULUS clocks.
//   borrow pulses once per period; underflow is high 1 of every MODULUS clocks.
//  Reset mid-count: overrides load and enable, and restores the reset values on that edge.
//  Unreachable state encodings are decoded to RUN with out=MODULUS-1 on the next edge.
// TESTING
//  1. reset=1 for 1 edge -> out=11, underflow=0, borrow=0, running=1.
//  2. enable=1 for 13 edges after reset -> out follows 10,9,...,1,0,11,10.
//     underflow=1 only while out=0. borrow=1 only in the cycle where out=11 after the wrap.
//  3. Count at 7. Assert load=1, load_value=3, enable=1 in the same cycle.
//     -> out=3 next cycle; the count then continues 2,1,0.
//  4. load_value=13 (also 15) -> out=11 (clamp). load_value=0 -> out=0, underflow=1, running=1.
//  5. enable=0 for 5 edges at out=4 -> out stays 4 and borrow stays 0.
//     Then reset=1 with enable=1 -> out=11.
//  6. AUTO_RELOAD=0, MODULUS=12: count from 2 with enable=1 -> out 1, then 0.
//     Next edge: borrow pulses once, running=0, and out stays 0 for 10 more edges.
//     load_value=5 -> running=1, out=5.

Source files
------------

// File: rtl/lab2_2_down.sv
// lab2_2_down: modulo-MODULUS down-counter with clamped parallel load, underflow level, borrow pulse and optional auto-reload
module lab2_2_down #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 12,
  parameter int AUTO_RELOAD = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             underflow,
  output logic             borrow,
  output logic             running
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD = (WIDTH + 1)'(MODULUS);
  typedef enum logic [1:0] {RUN = 2'd0, DONE = 2'd1} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    borrow_d = 1'b0;
    if (state_q != RUN && state_q != DONE) begin
      state_d = RUN;
      out_d   = MAX;
    end else if (load) begin
      out_d   = {1'b0, load_value} >= MOD ? MAX : load_value;
      state_d = RUN;
    end else if (state_q == DONE) begin
      out_d = '0;
    end else if (enable) begin
      out_d    = out_q != '0 ? out_q - 1'b1 : (AUTO_RELOAD != 0 ? MAX : '0);
      borrow_d = out_q == '0;
      state_d  = out_q == '0 && AUTO_RELOAD == 0 ? DONE : RUN;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      out_q    <= MAX;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
    end
  end
  assign out       = out_q;
  assign underflow = out_q == '0;
  assign borrow    = borrow_q;
  assign running   = state_q == RUN;
endmodule
